// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and counts retired instructions.
module multicycle_control_fsm #(
    parameter bit BNE_EN   = 1'b1,
    parameter bit JAL_EN   = 1'b1,
    parameter bit ITYPE_EN = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH:   if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)
                    state_next = S_MEMADR;
                else if (op == OP_RTYPE)
                    state_next = S_EXECR;
                else if (ITYPE_EN && op == OP_ITYPE)
                    state_next = S_EXECI;
                else if (JAL_EN && op == OP_JAL)
                    state_next = S_JAL;
                else if (op == OP_BRANCH &&
                         (funct3 == 3'b000 || (BNE_EN && funct3 == 3'b001)))
                    state_next = S_BRANCH;
                else
                    state_next = S_TRAP;
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: if (mem_ready) state_next = S_MEMWB;
            S_MEMWB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: if (mem_ready) begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_EXECR:   state_next = S_ALUWB;
            S_EXECI:   state_next = S_ALUWB;
            S_ALUWB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_JAL:     state_next = S_ALUWB;
            S_BRANCH: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default:   state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                retired_reg <= retired_reg + CNT_ONE;
        end
    end

    assign retired = retired_reg;

    always_comb begin
        unique case (op)
            OP_LW, OP_ITYPE: imm_src = 3'b000;
            OP_SW:           imm_src = 3'b001;
            OP_BRANCH:       imm_src = 3'b010;
            OP_JAL:          imm_src = 3'b011;
            default:         imm_src = 3'b000;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB:   reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = (funct3 == 3'b000) ? zero :
                            (funct3 == 3'b001) ? !zero : 1'b0;
            end
            default:   halted = 1'b1;
        endcase
        // Reset must suppress strobes immediately so no partial store/writeback escapes.
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule
